// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I control unit
// Purpose : stage enum, RV32I opcode values, datapath select encodings and the
//           DECODE dispatch function used by mc_ctrl_fsm.
// Ports   : none (package).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WRITE,
    MEM_WB,
    EX_R,
    EX_I,
    ALU_WB,
    BR,
    JAL,
    JALR_ADDR,
    JALR_WB,
    LUI,
    AUIPC,
    TRAP
  } stage_t;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand A
  localparam logic [1:0] ASEL_RS1    = 2'b00;
  localparam logic [1:0] ASEL_PC     = 2'b01;
  localparam logic [1:0] ASEL_OLD_PC = 2'b10;
  localparam logic [1:0] ASEL_ZERO   = 2'b11;

  // ALU operand B
  localparam logic [1:0] BSEL_RS2  = 2'b00;
  localparam logic [1:0] BSEL_IMM  = 2'b01;
  localparam logic [1:0] BSEL_FOUR = 2'b10;
  localparam logic [1:0] BSEL_ZERO = 2'b11;

  // PC source
  localparam logic [1:0] PCSEL_ALU_OUT       = 2'b00;
  localparam logic [1:0] PCSEL_ALU_REG       = 2'b01;
  localparam logic [1:0] PCSEL_ALU_REG_ALIGN = 2'b10;

  // Register-file write data source
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_ALU_REG = 2'b01;
  localparam logic [1:0] RES_MEM     = 2'b10;

  // Memory address source
  localparam logic ADDR_PC      = 1'b0;
  localparam logic ADDR_ALU_REG = 1'b1;

  // Core ALU operations; other ops are {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Stage that follows DECODE for a given opcode; unknown opcodes trap.
  function automatic stage_t decode_stage(input logic [6:0] op);
    stage_t s;
    case (op)
      OP_R:                s = EX_R;
      OP_I:                s = EX_I;
      OP_LOAD, OP_STORE:   s = MEM_ADDR;
      OP_BRANCH:           s = BR;
      OP_JAL:              s = JAL;
      OP_JALR:             s = JALR_ADDR;
      OP_LUI:              s = LUI;
      OP_AUIPC:            s = AUIPC;
      default:             s = TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/datapath bundle for the multicycle RV32I control unit
// Purpose : groups instruction fields, ALU flags, memory handshake and datapath
//           control outputs between the control unit and the datapath.
// Ports   : modport ctrl - control unit (reads IR fields/flags/mem_ready, drives controls)
//           modport dp   - datapath/memory side (mirror of ctrl)
interface mc_ctrl_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  alu_zero;
  logic                  alu_lt;
  logic                  alu_ltu;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic                  addr_sel;
  logic                  ir_write;
  logic                  pc_write;
  logic [1:0]            pc_sel;
  logic                  reg_write;
  logic [1:0]            result_sel;
  logic [1:0]            alu_a_sel;
  logic [1:0]            alu_b_sel;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  trap;

  modport ctrl (
    input  opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write,
           result_sel, alu_a_sel, alu_b_sel, alu_control, trap
  );

  modport dp (
    output opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write,
           result_sel, alu_a_sel, alu_b_sel, alu_control, trap
  );
endinterface

// File: rtl/mc_branch_cond.sv
// rtl/mc_branch_cond.sv - RV32I branch condition evaluation
// Purpose : turns branch funct3 and ALU compare flags into a taken decision.
// Ports   : funct3_i   branch type (inst[14:12])
//           zero_i     rs1 - rs2 == 0
//           lt_i       signed rs1 < rs2
//           ltu_i      unsigned rs1 < rs2
//           taken_o    branch taken (never set when illegal_o)
//           illegal_o  funct3 010/011, which are not branches
module mc_branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = zero_i;
      3'b001:  taken_o = !zero_i;
      3'b100:  taken_o = lt_i;
      3'b101:  taken_o = !lt_i;
      3'b110:  taken_o = ltu_i;
      3'b111:  taken_o = !ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle RV32I control unit with variable-latency memory
// Purpose : sequences FETCH/DECODE/execute/memory/writeback stages for a shared-memory
//           multicycle datapath, waits on mem_ready, traps on illegal opcodes,
//           illegal branch funct3 and (optionally) memory timeouts.
// Ports   : clk  - clock, all state on posedge
//           rst  - synchronous active-high reset (state FETCH, wait counter 0, trap 0)
//           bus  - mc_ctrl_if.ctrl: IR fields, ALU flags, mem_ready in;
//                  memory request, PC/IR/regfile enables, mux selects, alu_control, trap out
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.ctrl   bus
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT == 0) ? '0 : TIMEOUT_W'(MEM_TIMEOUT - 1);

  stage_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       mem_req_c, mem_we_c, addr_sel_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] pc_sel_c, result_sel_c, a_sel_c, b_sel_c;
  logic [3:0] alu_op_c;
  logic       wait_expired;

  logic       br_taken, br_illegal;

  // Only funct7[5] distinguishes RV32I ALU operations.
  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  mc_branch_cond u_branch_cond (
    .funct3_i  (bus.funct3),
    .zero_i    (bus.alu_zero),
    .lt_i      (bus.alu_lt),
    .ltu_i     (bus.alu_ltu),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    addr_sel_c   = ADDR_PC;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_sel_c     = PCSEL_ALU_OUT;
    reg_write_c  = 1'b0;
    result_sel_c = RES_ALU_OUT;
    a_sel_c      = ASEL_RS1;
    b_sel_c      = BSEL_RS2;
    alu_op_c     = ALU_ADD;

    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        a_sel_c   = ASEL_PC;
        b_sel_c   = BSEL_FOUR;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        // old_pc + imm lands in alu_reg as the branch/jal target
        a_sel_c = ASEL_OLD_PC;
        b_sel_c = BSEL_IMM;
        state_d = decode_stage(bus.opcode);
      end
      EX_R: begin
        alu_op_c = {bus.funct7[5], bus.funct3};
        state_d  = ALU_WB;
      end
      EX_I: begin
        // funct7[5] only matters for srai; for other I-ops those bits are immediate
        b_sel_c  = BSEL_IMM;
        alu_op_c = {(bus.funct3 == 3'b101) && bus.funct7[5], bus.funct3};
        state_d  = ALU_WB;
      end
      ALU_WB: begin
        reg_write_c  = 1'b1;
        result_sel_c = RES_ALU_REG;
        state_d      = FETCH;
      end
      MEM_ADDR: begin
        b_sel_c = BSEL_IMM;
        state_d = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req_c  = 1'b1;
        addr_sel_c = ADDR_ALU_REG;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WRITE: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        addr_sel_c = ADDR_ALU_REG;
        if (bus.mem_ready) state_d = FETCH;
      end
      MEM_WB: begin
        reg_write_c  = 1'b1;
        result_sel_c = RES_MEM;
        state_d      = FETCH;
      end
      BR: begin
        // ALU compares rs1 - rs2 for the flags; target was computed in DECODE
        alu_op_c   = ALU_SUB;
        pc_sel_c   = PCSEL_ALU_REG;
        pc_write_c = br_taken;
        state_d    = br_illegal ? TRAP : FETCH;
      end
      JAL: begin
        reg_write_c = 1'b1;
        a_sel_c     = ASEL_PC;
        b_sel_c     = BSEL_ZERO;
        pc_write_c  = 1'b1;
        pc_sel_c    = PCSEL_ALU_REG;
        state_d     = FETCH;
      end
      JALR_ADDR: begin
        b_sel_c = BSEL_IMM;
        state_d = JALR_WB;
      end
      JALR_WB: begin
        reg_write_c = 1'b1;
        a_sel_c     = ASEL_PC;
        b_sel_c     = BSEL_ZERO;
        pc_write_c  = 1'b1;
        pc_sel_c    = PCSEL_ALU_REG_ALIGN;
        state_d     = FETCH;
      end
      LUI: begin
        reg_write_c = 1'b1;
        a_sel_c     = ASEL_ZERO;
        b_sel_c     = BSEL_IMM;
        state_d     = FETCH;
      end
      AUIPC: begin
        reg_write_c = 1'b1;
        a_sel_c     = ASEL_OLD_PC;
        b_sel_c     = BSEL_IMM;
        state_d     = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    // A mem_ready in the last allowed cycle still completes the access.
    wait_expired = (MEM_TIMEOUT != 0) && mem_req_c && !bus.mem_ready &&
                   (wait_cnt_q == WAIT_LAST);
    if (wait_expired) state_d = TRAP;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req_c && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Enables are held low while reset is asserted so an aborted access does not
  // immediately turn into a new fetch request.
  assign bus.mem_req     = mem_req_c   & ~rst;
  assign bus.mem_we      = mem_we_c    & ~rst;
  assign bus.ir_write    = ir_write_c  & ~rst;
  assign bus.pc_write    = pc_write_c  & ~rst;
  assign bus.reg_write   = reg_write_c & ~rst;
  assign bus.addr_sel    = addr_sel_c;
  assign bus.pc_sel      = pc_sel_c;
  assign bus.result_sel  = result_sel_c;
  assign bus.alu_a_sel   = a_sel_c;
  assign bus.alu_b_sel   = b_sel_c;
  assign bus.alu_control = ALU_CTRL_W'(alu_op_c);
  assign bus.trap        = (state_q == TRAP);

endmodule
